kp_host: RTL

K-port host controller: the initiator end of the PC-FX controller port serial link. Given a start request, it runs one 32-bit frame (a latch pulse, then 32 clocked bits) and produces KP_LATCH, KP_CLK and KP_RW. In a read frame it shifts pad data in from KP_DIN; in a write frame it shifts host data out on KP_DOUT. It sits between the FX gate-array register logic and a pad responder such as hmi2kp, one instance per port.

---
 rtl/kp_host.sv | 135 +++++++++++++
 1 files changed

// File: rtl/kp_host.sv
// kp_host: PC-FX K-port host controller, runs one latch + 32-bit serial frame per START.
module kp_host #(
  parameter int HALF_DIV = 4
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        START,
  input  logic        WRITE,
  input  logic [31:0] TDATA,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        KP_LATCH,
  output logic        KP_CLK,
  output logic        KP_RW,
  output logic        KP_DOUT,
  input  logic        KP_DIN
);
  // divider also spans the double-length latch phase, so it needs 2*HALF_DIV states
  localparam int DW = $clog2(2 * HALF_DIV);
  localparam logic [DW-1:0] LAT_END = DW'(2 * HALF_DIV - 1);
  localparam logic [DW-1:0] HALF_END = DW'(HALF_DIV - 1);

  typedef enum logic [1:0] {IDLE, LATCH, CLK_LO, CLK_HI} state_t;

  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0] idx_q, idx_d;
  logic wr_q, wr_d;
  logic [31:0] tdata_q, tdata_d, shift_q, shift_d, rdata_q, rdata_d;
  logic busy_q, busy_d, done_q, done_d, latch_q, latch_d;
  logic kclk_q, kclk_d, rw_q, rw_d, dout_q, dout_d;

  always_comb begin
    state_d = state_q;
    div_d = div_q;
    idx_d = idx_q;
    wr_d = wr_q;
    tdata_d = tdata_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    busy_d = busy_q;
    done_d = 1'b0;
    latch_d = latch_q;
    kclk_d = kclk_q;
    rw_d = rw_q;
    dout_d = dout_q;
    if (CE) begin
      unique case (state_q)
        IDLE: if (START) begin
          wr_d = WRITE;
          tdata_d = TDATA;
          rw_d = ~WRITE;
          latch_d = 1'b1;
          busy_d = 1'b1;
          div_d = '0;
          idx_d = '0;
          state_d = LATCH;
        end
        LATCH: if (div_q == LAT_END) begin
          div_d = '0;
          latch_d = 1'b0;
          kclk_d = 1'b0;
          dout_d = wr_q & tdata_q[0];
          state_d = CLK_LO;
        end else div_d = div_q + 1'b1;
        CLK_LO: if (div_q == HALF_END) begin
          div_d = '0;
          kclk_d = 1'b1;
          shift_d[idx_q] = wr_q ? shift_q[idx_q] : KP_DIN;
          state_d = CLK_HI;
        end else div_d = div_q + 1'b1;
        CLK_HI: if (div_q == HALF_END) begin
          div_d = '0;
          if (idx_q == 5'd31) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            rw_d = 1'b1;
            dout_d = 1'b0;
            rdata_d = wr_q ? rdata_q : shift_q;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
            kclk_d = 1'b0;
            dout_d = wr_q & tdata_q[idx_q+5'd1];
            state_d = CLK_LO;
          end
        end else div_d = div_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // DONE follows done_d every CLK, so it clears on the next edge even with CE low
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q <= IDLE;
      div_q <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      tdata_q <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      latch_q <= 1'b0;
      kclk_q <= 1'b1;
      rw_q <= 1'b1;
      dout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      idx_q <= idx_d;
      wr_q <= wr_d;
      tdata_q <= tdata_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      latch_q <= latch_d;
      kclk_q <= kclk_d;
      rw_q <= rw_d;
      dout_q <= dout_d;
    end
  end

  assign RDATA = rdata_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign KP_LATCH = latch_q;
  assign KP_CLK = kclk_q;
  assign KP_RW = rw_q;
  assign KP_DOUT = dout_q;
endmodule
